// File: rtl/idct_butterfly.sv
`default_nettype none
// ============================================================================
//  Module      : idct_butterfly
//  Description : 8-point 1-D inverse DCT on one 32-bit signed row per cycle,
//                built as a 4-stage even/odd butterfly pipeline with a
//                global stall driven by output backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module idct_butterfly (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic signed [31:0] IN_DATA  [8],
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic signed [31:0] OUT_DATA [8]
);

    // Cosine constants in Q16 fixed point
    localparam logic signed [31:0] c_c1 = 32'sd64276;
    localparam logic signed [31:0] c_c2 = 32'sd60547;
    localparam logic signed [31:0] c_c3 = 32'sd54491;
    localparam logic signed [31:0] c_c4 = 32'sd46340;
    localparam logic signed [31:0] c_c5 = 32'sd36409;
    localparam logic signed [31:0] c_c6 = 32'sd25079;
    localparam logic signed [31:0] c_c7 = 32'sd12785;

    // Full 64-bit product, floor shift by 16, keep the low 32 bits
    function automatic logic signed [31:0] mul(input logic signed [31:0] v,
                                               input logic signed [31:0] c);
        logic signed [63:0] w_v;
        logic signed [63:0] w_c;
        w_v = v;
        w_c = c;
        return 32'((w_v * w_c) >>> 16);
    endfunction

    logic               w_stall;

    logic signed [31:0] w_a0, w_a1, w_b2, w_b3;
    logic signed [31:0] w_o [4];

    logic               r_s1_valid;
    logic signed [31:0] r_s1_a0, r_s1_a1, r_s1_b2, r_s1_b3;
    logic signed [31:0] r_s1_o [4];

    logic               r_s2_valid;
    logic signed [31:0] r_s2_e [4];
    logic signed [31:0] r_s2_o [4];

    logic               r_s3_valid;
    logic signed [31:0] r_s3_y [8];

    logic               r_s4_valid;
    logic signed [31:0] r_s4_x [8];

    // The whole pipeline freezes only when a finished row is not taken
    assign w_stall   = r_s4_valid && !OUT_READY;
    assign IN_READY  = !w_stall;
    assign OUT_VALID = r_s4_valid;
    assign OUT_DATA  = r_s4_x;

    // Stage-1 products: even half (a/b terms) and odd half (O0..O3)
    always_comb begin
        w_a0   = mul(IN_DATA[0] + IN_DATA[4], c_c4);
        w_a1   = mul(IN_DATA[0] - IN_DATA[4], c_c4);
        w_b2   = mul(IN_DATA[2], c_c6) - mul(IN_DATA[6], c_c2);
        w_b3   = mul(IN_DATA[2], c_c2) + mul(IN_DATA[6], c_c6);
        w_o[0] = mul(IN_DATA[1], c_c1) + mul(IN_DATA[3], c_c3)
               + mul(IN_DATA[5], c_c5) + mul(IN_DATA[7], c_c7);
        w_o[1] = mul(IN_DATA[1], c_c3) - mul(IN_DATA[3], c_c7)
               - mul(IN_DATA[5], c_c1) - mul(IN_DATA[7], c_c5);
        w_o[2] = mul(IN_DATA[1], c_c5) - mul(IN_DATA[3], c_c1)
               + mul(IN_DATA[5], c_c7) + mul(IN_DATA[7], c_c3);
        w_o[3] = mul(IN_DATA[1], c_c7) - mul(IN_DATA[3], c_c5)
               + mul(IN_DATA[5], c_c3) - mul(IN_DATA[7], c_c1);
    end

    // S1: register the products; data loads even for bubbles
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_s1_valid <= 1'b0;
            r_s1_a0    <= '0;
            r_s1_a1    <= '0;
            r_s1_b2    <= '0;
            r_s1_b3    <= '0;
            for (int i = 0; i < 4; i++) r_s1_o[i] <= '0;
        end else if (!w_stall) begin
            r_s1_valid <= IN_VALID;
            r_s1_a0    <= w_a0;
            r_s1_a1    <= w_a1;
            r_s1_b2    <= w_b2;
            r_s1_b3    <= w_b3;
            for (int i = 0; i < 4; i++) r_s1_o[i] <= w_o[i];
        end
    end

    // S2: combine even terms, carry odd terms through
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_s2_valid <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_s2_e[i] <= '0;
                r_s2_o[i] <= '0;
            end
        end else if (!w_stall) begin
            r_s2_valid <= r_s1_valid;
            r_s2_e[0]  <= r_s1_a0 + r_s1_b3;
            r_s2_e[1]  <= r_s1_a1 + r_s1_b2;
            r_s2_e[2]  <= r_s1_a1 - r_s1_b2;
            r_s2_e[3]  <= r_s1_a0 - r_s1_b3;
            for (int i = 0; i < 4; i++) r_s2_o[i] <= r_s1_o[i];
        end
    end

    // S3: final butterfly, mirrored outputs take the difference
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_s3_valid <= 1'b0;
            for (int i = 0; i < 8; i++) r_s3_y[i] <= '0;
        end else if (!w_stall) begin
            r_s3_valid <= r_s2_valid;
            for (int n = 0; n < 4; n++) begin
                r_s3_y[n]     <= r_s2_e[n] + r_s2_o[n];
                r_s3_y[7 - n] <= r_s2_e[n] - r_s2_o[n];
            end
        end
    end

    // S4: halve with floor rounding to undo the forward-transform gain
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_s4_valid <= 1'b0;
            for (int i = 0; i < 8; i++) r_s4_x[i] <= '0;
        end else if (!w_stall) begin
            r_s4_valid <= r_s3_valid;
            for (int i = 0; i < 8; i++) r_s4_x[i] <= r_s3_y[i] >>> 1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_idct_butterfly.sv
`default_nettype none
// ============================================================================
//  Module      : tb_idct_butterfly
//  Description : Self-checking bench for idct_butterfly; a reference model
//                fills a scoreboard at input acceptance and a monitor pops
//                and compares at every output transfer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_idct_butterfly;

    typedef logic [7:0][31:0] row_t;

    logic               CLOCK;
    logic               RESET;
    logic               IN_VALID;
    logic               IN_READY;
    logic signed [31:0] IN_DATA  [8];
    logic               OUT_VALID;
    logic               OUT_READY;
    logic signed [31:0] OUT_DATA [8];

    row_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    idct_butterfly dut (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .IN_DATA  (IN_DATA),
        .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY),
        .OUT_DATA (OUT_DATA)
    );

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    // Reference fixed-point multiply using 64-bit longint arithmetic
    function automatic int m(input int v, input int c);
        longint p;
        p = longint'(v) * longint'(c);
        p = p >>> 16;
        return int'(p);
    endfunction

    // Reference row transform, written out term by term from the equations
    function automatic row_t model(input row_t xi);
        int x[8];
        int a0, a1, b2, b3, o0, o1, o2, o3, e0, e1, e2, e3;
        int y[8];
        row_t r;
        for (int i = 0; i < 8; i++) x[i] = int'(xi[i]);
        a0 = m(x[0] + x[4], 46340);
        a1 = m(x[0] - x[4], 46340);
        b2 = m(x[2], 25079) - m(x[6], 60547);
        b3 = m(x[2], 60547) + m(x[6], 25079);
        o0 = m(x[1], 64276) + m(x[3], 54491) + m(x[5], 36409) + m(x[7], 12785);
        o1 = m(x[1], 54491) - m(x[3], 12785) - m(x[5], 64276) - m(x[7], 36409);
        o2 = m(x[1], 36409) - m(x[3], 64276) + m(x[5], 12785) + m(x[7], 54491);
        o3 = m(x[1], 12785) - m(x[3], 36409) + m(x[5], 54491) - m(x[7], 64276);
        e0 = a0 + b3;
        e1 = a1 + b2;
        e2 = a1 - b2;
        e3 = a0 - b3;
        y[0] = e0 + o0;  y[7] = e0 - o0;
        y[1] = e1 + o1;  y[6] = e1 - o1;
        y[2] = e2 + o2;  y[5] = e2 - o2;
        y[3] = e3 + o3;  y[4] = e3 - o3;
        for (int i = 0; i < 8; i++) r[i] = 32'(y[i] >>> 1);
        return r;
    endfunction

    function automatic row_t out_row();
        row_t r;
        for (int i = 0; i < 8; i++) r[i] = OUT_DATA[i];
        return r;
    endfunction

    function automatic row_t rand_row();
        row_t r;
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 1) == 0) r[i] = 32'($urandom_range(0, 4000)) - 32'd2000;
            else                           r[i] = $urandom();
        end
        return r;
    endfunction

    // Present one row until accepted; expected output enters the scoreboard
    task automatic drive_row(input row_t r);
        bit acc;
        acc = 1'b0;
        for (int i = 0; i < 8; i++) IN_DATA[i] = r[i];
        IN_VALID = 1'b1;
        for (int t = 0; t < 60 && !acc; t++) begin
            @(negedge CLOCK);
            if (IN_READY === 1'b1 && RESET === 1'b0) begin
                sb.push_back(model(r));
                acc = 1'b1;
            end
            @(posedge CLOCK);
            #1;
        end
        IN_VALID = 1'b0;
        if (!acc) begin
            n_checks++;
            $display("FAIL drive_row: row not accepted within 60 cycles");
        end
    endtask

    // Scoreboard monitor: every output transfer must match the oldest expected row
    always @(negedge CLOCK) begin
        row_t act;
        row_t exp;
        if (RESET === 1'b0 && OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
            act = out_row();
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL scoreboard: unexpected row %h, required none", act);
            end else begin
                exp = sb.pop_front();
                if (act !== exp)
                    $display("FAIL scoreboard: got %h required %h", act, exp);
                else
                    n_pass++;
            end
        end
    end

    task automatic test_reset();
        row_t act;
        RESET     = 1'b1;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        for (int i = 0; i < 8; i++) IN_DATA[i] = '0;
        repeat (2) @(posedge CLOCK);
        #1;
        RESET = 1'b0;
        @(negedge CLOCK);
        act = out_row();
        n_checks++;
        if (OUT_VALID !== 1'b0) $display("FAIL reset_out_valid: got %b required 0", OUT_VALID);
        else n_pass++;
        n_checks++;
        if (IN_READY !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", IN_READY);
        else n_pass++;
        n_checks++;
        if (act !== '0) $display("FAIL reset_out_data: got %h required 0", act);
        else n_pass++;
        @(posedge CLOCK);
        #1;
    endtask

    // DC, negative DC and odd-basis rows with hand-derived results and latency
    task automatic test_known_vectors();
        row_t vin [3];
        row_t vexp[3];
        row_t a;
        string nm[3];
        int    dc_p, dc_n;
        dc_p = 22;
        dc_n = -23;
        nm[0] = "dc"; nm[1] = "neg_dc"; nm[2] = "odd_basis";
        vin[0] = '0; vin[0][0] = 32'd64;
        vin[1] = '0; vin[1][0] = -32'sd64;
        vin[2] = '0; vin[2][1] = 32'd65536;
        for (int i = 0; i < 8; i++) begin
            vexp[0][i] = 32'(dc_p);
            vexp[1][i] = 32'(dc_n);
        end
        vexp[2][0] = 32'sd32138;   vexp[2][1] = 32'sd27245;
        vexp[2][2] = 32'sd18204;   vexp[2][3] = 32'sd6392;
        vexp[2][4] = -32'sd6393;   vexp[2][5] = -32'sd18205;
        vexp[2][6] = -32'sd27246;  vexp[2][7] = -32'sd32138;
        for (int v = 0; v < 3; v++) begin
            drive_row(vin[v]);
            for (int k = 1; k <= 3; k++) @(negedge CLOCK);
            n_checks++;
            if (OUT_VALID !== 1'b0) $display("FAIL %s_early: OUT_VALID got %b required 0 at cycle 3", nm[v], OUT_VALID);
            else n_pass++;
            @(negedge CLOCK);
            a = out_row();
            n_checks++;
            if (OUT_VALID !== 1'b1 || a !== vexp[v])
                $display("FAIL %s: valid %b data %h required valid 1 data %h", nm[v], OUT_VALID, a, vexp[v]);
            else n_pass++;
            @(posedge CLOCK);
            #1;
        end
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge CLOCK);
        n_checks++;
        if (sb.size() != 0) $display("FAIL known_drain: %0d rows pending required 0", sb.size());
        else n_pass++;
        @(posedge CLOCK);
        #1;
    endtask

    task automatic test_back_to_back();
        int run;
        OUT_READY = 1'b1;
        run = 0;
        fork
            begin
                for (int r = 0; r < 8; r++) drive_row(rand_row());
            end
            begin
                for (int i = 0; i < 20 && OUT_VALID !== 1'b1; i++) @(negedge CLOCK);
                while (OUT_VALID === 1'b1 && run < 20) begin
                    run++;
                    @(negedge CLOCK);
                end
            end
        join
        n_checks++;
        if (run != 8) $display("FAIL b2b_run: consecutive valid cycles %0d required 8", run);
        else n_pass++;
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge CLOCK);
        n_checks++;
        if (sb.size() != 0) $display("FAIL b2b_drain: %0d rows pending required 0", sb.size());
        else n_pass++;
        @(posedge CLOCK);
        #1;
    endtask

    task automatic test_backpressure();
        row_t hold;
        int   seen;
        OUT_READY = 1'b1;
        fork
            begin
                for (int r = 0; r < 10; r++) drive_row(rand_row());
            end
            begin
                for (int i = 0; i < 20 && OUT_VALID !== 1'b1; i++) begin
                    @(posedge CLOCK);
                    #1;
                end
                OUT_READY = 1'b0;
                hold = out_row();
                for (int c = 0; c < 6; c++) begin
                    @(negedge CLOCK);
                    n_checks++;
                    if (IN_READY !== 1'b0 || OUT_VALID !== 1'b1 || out_row() !== hold)
                        $display("FAIL stall_c%0d: in_ready %b valid %b data %h required 0 1 %h",
                                 c, IN_READY, OUT_VALID, out_row(), hold);
                    else n_pass++;
                    @(posedge CLOCK);
                    #1;
                end
                OUT_READY = 1'b1;
            end
        join
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge CLOCK);
        n_checks++;
        if (sb.size() != 0) $display("FAIL bp_drain: %0d rows pending required 0", sb.size());
        else n_pass++;
        seen = 0;
        repeat (5) begin
            @(negedge CLOCK);
            if (OUT_VALID === 1'b1) seen++;
        end
        n_checks++;
        if (seen != 0) $display("FAIL bp_extra: %0d extra valid cycles required 0", seen);
        else n_pass++;
        @(posedge CLOCK);
        #1;
    endtask

    task automatic test_reset_midflight();
        row_t r;
        int   seen;
        OUT_READY = 1'b1;
        for (int k = 0; k < 3; k++) drive_row(rand_row());
        // Three rows now sit in S1..S3; offer a fourth during reset as well
        r = rand_row();
        for (int i = 0; i < 8; i++) IN_DATA[i] = r[i];
        IN_VALID = 1'b1;
        RESET    = 1'b1;
        @(posedge CLOCK);
        #1;
        RESET    = 1'b0;
        IN_VALID = 1'b0;
        sb.delete();
        @(negedge CLOCK);
        n_checks++;
        if (OUT_VALID !== 1'b0 || out_row() !== '0 || IN_READY !== 1'b1)
            $display("FAIL mid_reset: valid %b data %h in_ready %b required 0 0 1",
                     OUT_VALID, out_row(), IN_READY);
        else n_pass++;
        seen = 0;
        repeat (8) begin
            @(negedge CLOCK);
            if (OUT_VALID === 1'b1) seen++;
        end
        n_checks++;
        if (seen != 0) $display("FAIL mid_reset_leak: %0d rows emerged required 0", seen);
        else n_pass++;
        @(posedge CLOCK);
        #1;
    endtask

    initial begin
        test_reset();
        test_known_vectors();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/idct_butterfly.md
IDCT_BUTTERFLY -- requirements
Module: idct_butterfly

Interface
REQ-001 The block SHALL have no parameters; the data width is fixed at 32-bit signed.
REQ-002 The block SHALL have port CLOCK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port IN_VALID, input, 1 bit: IN_DATA holds one 8-coefficient row.
REQ-005 The block SHALL have port IN_READY, output, 1 bit: the block accepts the row this cycle.
REQ-006 The block SHALL have port IN_DATA[8], input, 32 bits signed each: coefficients X0..X7 in natural frequency order.
REQ-007 The block SHALL have port OUT_VALID, output, 1 bit: OUT_DATA holds one reconstructed row.
REQ-008 The block SHALL have port OUT_READY, input, 1 bit: the consumer accepts the row this cycle.
REQ-009 The block SHALL have port OUT_DATA[8], output, 32 bits signed each: spatial samples x0..x7 in natural order.

Function
REQ-010 The block SHALL transfer an input row when IN_VALID && IN_READY, and an output row when OUT_VALID && OUT_READY.
REQ-011 The block SHALL be a 4-stage pipeline (S1..S4), each stage carrying a valid bit; OUT_VALID = S4 valid, OUT_DATA = S4 registers.
REQ-012 The block SHALL define stall = OUT_VALID && !OUT_READY, and IN_READY = !stall (combinational).
REQ-013 When stall is high, all stage registers and valid bits SHALL hold; otherwise every stage advances, and S1 valid loads IN_VALID.
REQ-014 Latency SHALL be 4 cycles from acceptance to OUT_VALID with no stall; throughput SHALL be 1 row/cycle.
REQ-015 Stages SHALL load data regardless of their valid bit when not stalled; invalid data is don't-care and never affects valid rows.
REQ-016 mul(v,c) SHALL be (v*c) computed at 64-bit signed width, then >>>16 (arithmetic shift, floor), truncated to 32 bits; adds and subtracts wrap at 32 bits.
REQ-017 The constants SHALL be: C1=64276, C2=60547, C3=54491, C4=46340, C5=36409, C6=25079, C7=12785.
REQ-018 S1 SHALL compute:
- a0=mul(X0+X4,C4), a1=mul(X0-X4,C4)
- b2=mul(X2,C6)-mul(X6,C2), b3=mul(X2,C2)+mul(X6,C6)
- O0=mul(X1,C1)+mul(X3,C3)+mul(X5,C5)+mul(X7,C7)
- O1=mul(X1,C3)-mul(X3,C7)-mul(X5,C1)-mul(X7,C5)
- O2=mul(X1,C5)-mul(X3,C1)+mul(X5,C7)+mul(X7,C3)
- O3=mul(X1,C7)-mul(X3,C5)+mul(X5,C3)-mul(X7,C1)
REQ-019 S2 SHALL compute E0=a0+b3, E1=a1+b2, E2=a1-b2, E3=a0-b3, and pass O0..O3 unchanged.
REQ-020 S3 SHALL compute, for n=0..3: y[n]=E[n]+O[n] and y[7-n]=E[n]-O[n].
REQ-021 S4 SHALL compute x[n]=y[n]>>>1 for n=0..7, giving a 1/2 scale that mirrors the forward transform's output shift.
REQ-022 On an output transfer in the same cycle as an input acceptance, both transfers SHALL complete (no bubble).
REQ-023 When IN_VALID is asserted while IN_READY is low, the row SHALL NOT be accepted; the source holds it.

Reset
REQ-024 While RESET=1 at a clock edge, all valid bits and all stage data registers SHALL clear to 0; OUT_VALID=0, OUT_DATA all 0, and IN_READY=1 after the edge.
REQ-025 A reset mid-operation SHALL discard all in-flight rows; no partial row appears at the output after reset.
REQ-026 Input presented in a cycle with RESET=1 SHALL be ignored.

Verification
REQ-027 The bench SHALL cover DC: X0=64, rest 0, OUT_READY=1 -> 4 cycles later OUT_VALID=1, all x[n]=22.
REQ-028 The bench SHALL cover negative DC: X0=-64, rest 0 -> all x[n]=-23 (floor rounding).
REQ-029 The bench SHALL cover odd basis: X1=65536, rest 0 -> x0..x7 = 32138, 27245, 18204, 6392, -6393, -18205, -27246, -32138.
REQ-030 The bench SHALL cover back-to-back rows: 8 consecutive rows, OUT_READY=1 -> 8 consecutive OUT_VALID cycles, in order, each matching the bit-exact model in REQ-016..021.
REQ-031 The bench SHALL cover backpressure: stream rows, hold OUT_READY=0 for 6 cycles -> IN_READY=0 while OUT_VALID=1, OUT_DATA stable, no row lost or duplicated after release.
REQ-032 The bench SHALL cover reset: RESET=1 for 1 cycle with 3 rows in flight -> next cycle OUT_VALID=0, OUT_DATA=0, and none of those 3 rows emerges afterwards.
